// File: rtl/regfile_mp.sv
// regfile_mp - multi-port general-purpose register file for the decode stage.
//
// NUM_RD combinational read ports, two write ports (0 = WB stage, 1 = second
// retiring slot), register 0 hardwired to zero. After reset a clear sequencer
// zeroes entries 1..DEPTH-1, one per cycle, so the array itself needs no reset
// and can map onto reset-less RAM.
//
// Optional build macro: REGFILE_FWD_EN enables same-cycle write-to-read
// forwarding (port 1 data has priority over port 0 data).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   we0/waddr0/wdata0        write port 0
//   we1/waddr1/wdata1        write port 1 (wins on same-address collision)
//   re      [NUM_RD]         per-port read enable
//   raddr   [NUM_RD*ADDR_W]  packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rdata   [NUM_RD*DATA_W]  packed read data, port i at [i*DATA_W +: DATA_W]
//   ready                    high once the clear sweep is complete
//   wr_drop                  one-cycle pulse: nonzero-address write discarded during sweep
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     ready,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic               wr_drop_q, wr_drop_d;

    // Entry 0 is never written; reads of address 0 are forced to zero below.
    logic [DATA_W-1:0]  regs [DEPTH];

    logic wr_req0, wr_req1;
    logic wr0_en, wr1_en;

    // A "qualified" request is an enabled write to a nonzero address; writes to
    // address 0 vanish silently and never count as drops.
    assign wr_req0 = we0 && (waddr0 != '0);
    assign wr_req1 = we1 && (waddr1 != '0);

    // Port 1 wins a same-address collision, so port 0 is suppressed there.
    assign wr0_en = (state_q == RUN) && wr_req0 && !(wr_req1 && (waddr1 == waddr0));
    assign wr1_en = (state_q == RUN) && wr_req1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_drop_d = 1'b0;
        case (state_q)
            INIT: begin
                idx_d     = idx_q + 1'b1;
                wr_drop_d = wr_req0 || wr_req1;
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            idx_q     <= {{(ADDR_W-1){1'b0}}, 1'b1};
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Reset-less storage: the sweep provides the initial zeroes.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            regs[idx_q] <= '0;
        end else begin
            if (wr0_en) begin
                regs[waddr0] <= wdata0;
            end
            if (wr1_en) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    assign ready   = (state_q == RUN);
    assign wr_drop = wr_drop_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd;

            assign ra = raddr[gi*ADDR_W +: ADDR_W];

            always_comb begin
                rd = '0;
                if (!rst && ready && re[gi] && (ra != '0)) begin
                    rd = regs[ra];
`ifdef REGFILE_FWD_EN
                    if (we1 && (waddr1 == ra)) begin
                        rd = wdata1;
                    end else if (we0 && (waddr0 == ra)) begin
                        rd = wdata0;
                    end
`endif
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NRD = 4;
    localparam int SWEEP = 31;

    logic              clk = 1'b0;
    logic              rst;
    logic              we0, we1;
    logic [AW-1:0]     waddr0, waddr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NRD-1:0]    re;
    logic [NRD*AW-1:0] raddr;
    logic [NRD*DW-1:0] rdata;
    logic              ready;
    logic              wr_drop;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD)) dut (
        .clk(clk), .rst(rst),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata),
        .ready(ready), .wr_drop(wr_drop)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a plain array plus a count of clean edges since reset.
    logic [DW-1:0] m_mem [32];
    int            m_cnt;
    logic          m_drop;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int p);
        logic [AW-1:0] a;
        a = raddr[p*AW +: AW];
        if (rst || m_cnt < SWEEP || !re[p] || a == 0) return '0;
`ifdef REGFILE_FWD_EN
        if (we1 && waddr1 == a) return wdata1;
        if (we0 && waddr0 == a) return wdata0;
`endif
        return m_mem[a];
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, " ready"}, {31'd0, ready}, {31'd0, (!rst && m_cnt >= SWEEP)});
        check({tag, " wr_drop"}, {31'd0, wr_drop}, {31'd0, m_drop});
        for (int p = 0; p < NRD; p++)
            check($sformatf("%s rdata%0d", tag, p), rdata[p*DW +: DW], m_read(p));
    endtask

    task automatic idle_inputs();
        we0 = 0; waddr0 = 0; wdata0 = 0;
        we1 = 0; waddr1 = 0; wdata1 = 0;
        re = '0; raddr = '0;
    endtask

    task automatic set_read_all(input logic [AW-1:0] a);
        re = '1;
        for (int p = 0; p < NRD; p++) raddr[p*AW +: AW] = a;
    endtask

    // Called just after a negedge with inputs driven; checks, then advances one edge.
    task automatic cycle(input string tag);
        #2;
        check_outputs(tag);
        @(posedge clk);
        if (!rst) begin
            if (m_cnt < SWEEP) begin
                m_drop = (we0 && waddr0 != 0) || (we1 && waddr1 != 0);
                m_cnt++;
            end else begin
                m_drop = 1'b0;
                if (we0 && waddr0 != 0) m_mem[waddr0] = wdata0;
                if (we1 && waddr1 != 0) m_mem[waddr1] = wdata1;
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_drop = 1'b0;
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #2;
        check_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_to_ready();
        idle_inputs();
        set_read_all(5'd5);
        for (int i = 0; i < SWEEP; i++) cycle("sweep");
    endtask

    typedef struct {
        logic          we0;
        logic [AW-1:0] waddr0;
        logic [DW-1:0] wdata0;
        logic          we1;
        logic [AW-1:0] waddr1;
        logic [DW-1:0] wdata1;
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1, 5'd3,  32'hDEADBEEF, 0, 5'd0,  32'h0,        5'd3,  32'hDEADBEEF};
        vecs[1] = '{1, 5'd7,  32'h00000011, 1, 5'd7,  32'h00000022, 5'd7,  32'h00000022};
        vecs[2] = '{1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h00000000};
        vecs[3] = '{0, 5'd9,  32'h0BADF00D, 1, 5'd31, 32'h12345678, 5'd31, 32'h12345678};
        vecs[4] = '{1, 5'd5,  32'h0000000A, 1, 5'd6,  32'h0000000B, 5'd5,  32'h0000000A};
        vecs[5] = '{0, 5'd6,  32'h77777777, 0, 5'd6,  32'h88888888, 5'd6,  32'h0000000B};

        idle_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Sweep with all ports reading 5, then ready rises.
        run_to_ready();
        #2;
        check("ready after sweep", {31'd0, ready}, 32'd1);
        check("rdata5 after sweep", rdata[0 +: DW], 32'd0);

        // Table: write cycle, then a quiet read cycle with a constant expectation.
        for (int v = 0; v < 6; v++) begin
            idle_inputs();
            we0 = vecs[v].we0; waddr0 = vecs[v].waddr0; wdata0 = vecs[v].wdata0;
            we1 = vecs[v].we1; waddr1 = vecs[v].waddr1; wdata1 = vecs[v].wdata1;
            set_read_all(vecs[v].rd_addr);
            cycle($sformatf("vec%0d wr", v));
            we0 = 0; we1 = 0;
            #2;
            for (int p = 0; p < NRD; p++)
                check($sformatf("vec%0d port%0d", v, p), rdata[p*DW +: DW], vecs[v].exp);
            check($sformatf("vec%0d wr_drop", v), {31'd0, wr_drop}, 32'd0);
            cycle($sformatf("vec%0d rd", v));
        end

        // Same-cycle read of a register being written.
        idle_inputs();
        we0 = 1; waddr0 = 5'd3; wdata0 = 32'hCAFEF00D;
        set_read_all(5'd3);
        #2;
`ifdef REGFILE_FWD_EN
        check("fwd same cycle", rdata[0 +: DW], 32'hCAFEF00D);
`else
        check("nofwd same cycle", rdata[0 +: DW], 32'hDEADBEEF);
`endif
        #0;
        // cycle() adds its own #2 before sampling; still well before the edge.
        cycle("fwd wr");
        we0 = 0;
        #2;
        check("fwd next cycle", rdata[0 +: DW], 32'hCAFEF00D);
        cycle("fwd rd");

        // Write during sweep cycle 4 is dropped and flagged.
        do_reset();
        idle_inputs();
        for (int i = 0; i < 3; i++) cycle("init");
        we0 = 1; waddr0 = 5'd9; wdata0 = 32'h55;
        cycle("init wr");
        we0 = 0;
        #2;
        check("wr_drop pulse", {31'd0, wr_drop}, 32'd1);
        cycle("init after");
        #2;
        check("wr_drop cleared", {31'd0, wr_drop}, 32'd0);
        for (int i = 0; i < SWEEP - 5; i++) cycle("init rest");
        set_read_all(5'd9);
        #2;
        check("reg9 after init", rdata[0 +: DW], 32'd0);
        cycle("reg9 rd");

        // Async reset in RUN, then mid-sweep reset; reg 12 must come back zero.
        we0 = 1; waddr0 = 5'd12; wdata0 = 32'hA5;
        cycle("wr12");
        idle_inputs();
        set_read_all(5'd12);
        #2;
        check("reg12 before rst", rdata[0 +: DW], 32'hA5);
        rst = 1'b1;
        #1;
        check("async ready drop", {31'd0, ready}, 32'd0);
        check("async rdata zero", rdata[0 +: DW], 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) cycle("sweep2");
        rst = 1'b1;
        #1;
        check("midsweep ready", {31'd0, ready}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < SWEEP; i++) cycle("sweep3");
        #2;
        check("ready after restart", {31'd0, ready}, 32'd1);
        for (int p = 0; p < NRD; p++)
            check($sformatf("reg12 port%0d", p), rdata[p*DW +: DW], 32'd0);
        cycle("reg12 rd");

        // Randomised traffic against the model; small address range forces collisions.
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom); waddr0 = AW'($urandom_range(0, 9)); wdata0 = $urandom;
            we1 = 1'($urandom); waddr1 = AW'($urandom_range(0, 9)); wdata1 = $urandom;
            re = NRD'($urandom);
            for (int p = 0; p < NRD; p++) raddr[p*AW +: AW] = AW'($urandom_range(0, 11));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the OpenMIPS32 decode stage; successor to the fixed two-read/one-write `regfile` block. It provides `NUM_RD` combinational read ports and two write ports (`0` = WB stage, `1` = second retiring slot), with register 0 hardwired to zero. It also contains a post-reset clear sequencer: after reset it zeroes the array one entry per cycle, which lets the array map onto reset-less RAM. Compile-time write-to-read forwarding is optional.

## Interface
- `DATA_W`, 32, register width in bits.
- `ADDR_W`, 5, register address width; `DEPTH = 2**ADDR_W` entries.
- `NUM_RD`, 2, number of read ports, legal range 1..4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `we0`  in  1  write enable, port 0.
- `waddr0`  in  `ADDR_W`  write address, port 0.
- `wdata0`  in  `DATA_W`  write data, port 0.
- `we1`  in  1  write enable, port 1.
- `waddr1`  in  `ADDR_W`  write address, port 1.
- `wdata1`  in  `DATA_W`  write data, port 1.
- `re`  in  `NUM_RD`  per-port read enable; bit i belongs to port i.
- `raddr`  in  `NUM_RD*ADDR_W`  packed read addresses; port i is slice `[i*ADDR_W +: ADDR_W]`.
- `rdata`  out  `NUM_RD*DATA_W`  packed read data; port i is slice `[i*DATA_W +: DATA_W]`.
- `ready`  out  1  high once the clear sweep has finished.
- `wr_drop`  out  1  registered one-cycle pulse: a write with a nonzero address was discarded because `ready` was low.

## Operation
- FSM states: `INIT`, `RUN`.
- While `rst` is high, the FSM is forced to `INIT` and the sweep counter `idx` to 1.
- In `INIT`, each cycle writes `regs[idx] <= 0` and increments `idx`.
- When `idx == DEPTH-1` has been written, the FSM moves to `RUN`.
- `RUN` is held until the next reset.
- Entry 0 is never stored. Every read of address 0 returns 0, and every write to address 0 is silently dropped; this does not raise `wr_drop`.
- Writes in `RUN`:
  - Port 0 writes when `we0` is high and `waddr0 != 0`.
  - Port 1 writes when `we1` is high and `waddr1 != 0`.
  - Both ports enabled to the same address: port 1 wins and port 0 is discarded.
- Writes in `INIT`: user writes are ignored. `wr_drop` is high on the next cycle if either qualified enable was present.
- Read port i output, first matching rule wins:
  - `rst` high, or `ready` low: 0.
  - `re[i]` low: 0.
  - `raddr_i == 0`: 0.
  - Forwarding hit (see Configuration): the forwarded data.
  - Otherwise: `regs[raddr_i]`.
- Read ports are independent. Any number of ports may read the same address in the same cycle.

## Timing
- Reset values: `ready` = 0, `wr_drop` = 0, all `rdata` slices = 0. Array contents are undefined until the sweep completes.
- Sweep length: `DEPTH-1` cycles after the first rising edge with `rst` low. `ready` rises on the edge that writes entry `DEPTH-1`. With the defaults, `ready` is high 31 cycles after reset release.
- Reset asserted mid-sweep or in `RUN`:
  - `ready` drops immediately, asynchronously.
  - `rdata` is forced to 0.
  - The sweep restarts from entry 1 after release.
- Read latency: 0 cycles, fully combinational from `raddr`, `re` and the array.
- Write latency: data is visible in the array from the cycle after the write edge.
- A `wr_drop` pulse is exactly one cycle wide per offending cycle. Back-to-back offending cycles hold it high.

## Configuration
- Macro: `REGFILE_FWD_EN`.
- Defined:
  - Port i returns `wdata1` when `we1` is high and `waddr1 == raddr_i`.
  - Otherwise it returns `wdata0` when `we0` is high and `waddr0 == raddr_i`.
  - This happens in the same cycle as the write, giving zero write-to-read latency.
  - Applies only in `RUN`, to nonzero addresses, with `re[i]` high.
- Undefined: reads return array contents only, so a same-cycle write appears on the following cycle.

## Test plan
- Reset release: `re` all high, `raddr` all 5 -> `ready` low and `rdata` 0 for 31 cycles, then `ready` = 1 and `rdata` reads 0.
- In `RUN`: `we0` = 1, `waddr0` = 3, `wdata0` = 0xDEADBEEF; port 0 reads 3 -> with `REGFILE_FWD_EN`, same cycle shows 0xDEADBEEF; without it, shows 0 that cycle and 0xDEADBEEF the next.
- Dual write collision: `we0` = `we1` = 1, both addresses 7, `wdata0` = 0x11, `wdata1` = 0x22 -> reg 7 reads 0x22.
- Write 0xFFFFFFFF to address 0 on both ports -> every port reading address 0 returns 0; `wr_drop` stays 0.
- Write during `INIT` (`we0` = 1, `waddr0` = 9, `wdata0` = 0x55 on sweep cycle 4) -> `wr_drop` = 1 for one cycle; after `ready`, reg 9 reads 0.
- `NUM_RD` = 4: write 0xA5 to reg 12, then assert `rst` at sweep cycle 10 and release -> `ready` = 0 immediately; after 31 more cycles `ready` = 1 and all four ports reading 12 return 0.
